// File: rtl/rv_decode_stage_if.sv
// Fetch/regfile/execute-side signal bundle for the RV32I decode stage.
// The slave modport is the decode stage; the master modport is its surroundings.
interface rv_decode_stage_if #(parameter int CNT_W = 32);
  logic             flush;
  logic             if_valid;
  logic [31:0]      if_instr;
  logic [31:0]      if_pc;
  logic             id_ready;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      operand1;
  logic [31:0]      operand2;
  logic [5:0]       ex_type;
  logic [4:0]       rd_addr;
  logic             reg_write;
  logic             illegal;
  logic [CNT_W-1:0] decoded_count;

  modport master (
    output flush, if_valid, if_instr, if_pc, rs1_data, rs2_data, ex_ready,
    input  id_ready, rs1_addr, rs2_addr, ex_valid, operand1, operand2,
           ex_type, rd_addr, reg_write, illegal, decoded_count
  );

  modport slave (
    input  flush, if_valid, if_instr, if_pc, rs1_data, rs2_data, ex_ready,
    output id_ready, rs1_addr, rs2_addr, ex_valid, operand1, operand2,
           ex_type, rd_addr, reg_write, illegal, decoded_count
  );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I integer decode (OP, OP-IMM, LUI, AUIPC) with a registered ALU bundle
// towards execute and a counter of legal instructions handed over.
module rv_decode_stage #(
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  rv_decode_stage_if.slave   bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt_i;
  logic [31:0] shamt_r;

  logic        dec_legal;
  logic [5:0]  dec_type;
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic        accept;

  logic             ex_valid_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic [5:0]       type_q;
  logic [4:0]       rd_q;
  logic             rw_q;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;

  assign instr   = bus.if_instr;
  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt_i = {27'b0, instr[24:20]};
  assign shamt_r = {27'b0, bus.rs2_data[4:0]};

  assign bus.rs1_addr = instr[19:15];
  assign bus.rs2_addr = instr[24:20];

  // Malformed encodings fall through with type 63 and zero operands.
  always_comb begin
    dec_legal = 1'b0;
    dec_type  = 6'd63;
    dec_op1   = '0;
    dec_op2   = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          dec_legal = 1'b1;
          dec_op1   = bus.rs1_data;
          dec_op2   = bus.rs2_data;
          case (funct3)
            3'b000:  dec_type = (funct7 == F7_ALT) ? 6'd2 : 6'd0;
            3'b001:  begin dec_type = 6'd9;  dec_op2 = shamt_r; end
            3'b010:  dec_type = 6'd15;
            3'b011:  dec_type = 6'd17;
            3'b100:  dec_type = 6'd7;
            3'b101:  begin dec_type = (funct7 == F7_ALT) ? 6'd13 : 6'd11; dec_op2 = shamt_r; end
            3'b110:  dec_type = 6'd5;
            default: dec_type = 6'd3;
          endcase
        end
      end
      OPC_OP_IMM: begin
        if ((funct3 != 3'b001 && funct3 != 3'b101) || funct7 == F7_BASE ||
            (funct3 == 3'b101 && funct7 == F7_ALT)) begin
          dec_legal = 1'b1;
          dec_op1   = bus.rs1_data;
          dec_op2   = imm_i;
          case (funct3)
            3'b000:  dec_type = 6'd1;
            3'b001:  begin dec_type = 6'd10; dec_op2 = shamt_i; end
            3'b010:  dec_type = 6'd16;
            3'b011:  dec_type = 6'd18;
            3'b100:  dec_type = 6'd8;
            3'b101:  begin dec_type = (funct7 == F7_ALT) ? 6'd14 : 6'd12; dec_op2 = shamt_i; end
            3'b110:  dec_type = 6'd6;
            default: dec_type = 6'd4;
          endcase
        end
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_type  = 6'd19;
        dec_op2   = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_type  = 6'd20;
        dec_op1   = bus.if_pc;
        dec_op2   = imm_u;
      end
      default: ;
    endcase
  end

  assign bus.id_ready = !ex_valid_q || bus.ex_ready;
  assign accept       = bus.if_valid && bus.id_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      type_q     <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      ill_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (accept) begin
        ex_valid_q <= 1'b1;
        op1_q      <= dec_op1;
        op2_q      <= dec_op2;
        type_q     <= dec_type;
        rd_q       <= instr[11:7];
        rw_q       <= dec_legal && (instr[11:7] != 5'd0);
        ill_q      <= !dec_legal;
      end else if (bus.ex_ready && ex_valid_q) begin
        ex_valid_q <= 1'b0;
      end
      if (accept && dec_legal) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.operand1      = op1_q;
  assign bus.operand2      = op2_q;
  assign bus.ex_type       = type_q;
  assign bus.rd_addr       = rd_q;
  assign bus.reg_write     = rw_q;
  assign bus.illegal       = ill_q;
  assign bus.decoded_count = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: stimulus queues expected bundles,
// a negedge monitor pops and compares them on each execute handshake.
module tb_rv_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_decode_stage_if #(.CNT_W(32)) bus ();
  rv_decode_stage #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [5:0]  ty;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [5:0] ty, input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] rd, input logic rw, input logic ill, input logic [31:0] cnt);
    exp_t e;
    e.ty = ty; e.op1 = op1; e.op2 = op2; e.rd = rd; e.rw = rw; e.ill = ill; e.cnt = cnt;
    return e;
  endfunction

  // Called at posedge+1; the instruction is accepted at the following edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    logic [31:0] w;
    w = instr;
    bus.if_instr = instr;
    bus.if_pc    = pc;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.if_valid = 1'b1;
    sb.push_back(e);
    #1;
    chk("rs1_addr", 32'(bus.rs1_addr), 32'(w[19:15]));
    chk("rs2_addr", 32'(bus.rs2_addr), 32'(w[24:20]));
    @(posedge clk);
    #1 bus.if_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ex_valid"}, 32'(bus.ex_valid), 32'd0);
    chk({tag, "_operand1"}, bus.operand1, 32'd0);
    chk({tag, "_operand2"}, bus.operand2, 32'd0);
    chk({tag, "_ex_type"}, 32'(bus.ex_type), 32'd0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    chk({tag, "_reg_write"}, 32'(bus.reg_write), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
    chk({tag, "_count"}, bus.decoded_count, 32'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ex_valid && bus.ex_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bundle: got ex_type %0d, expected no bundle at %0t", bus.ex_type, $time);
        end else begin
          e = sb.pop_front();
          chk("ex_type", 32'(bus.ex_type), 32'(e.ty));
          chk("operand1", bus.operand1, e.op1);
          chk("operand2", bus.operand2, e.op2);
          chk("rd_addr", 32'(bus.rd_addr), 32'(e.rd));
          chk("reg_write", 32'(bus.reg_write), 32'(e.rw));
          chk("illegal", 32'(bus.illegal), 32'(e.ill));
          chk("decoded_count", bus.decoded_count, e.cnt);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t held;
    bus.flush = 1'b0; bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_id_ready", 32'(bus.id_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h00500093, 32'h0, 32'd0, 32'd0, mk(6'd1, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 32'd1));           // addi x1,x0,5
    issue(32'h402081B3, 32'h4, 32'd10, 32'd3, mk(6'd2, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0, 32'd2));         // sub x3,x1,x2
    issue(32'h40435293, 32'h8, 32'h80000000, 32'd0, mk(6'd14, 32'h80000000, 32'd4, 5'd5, 1'b1, 1'b0, 32'd3)); // srai
    issue(32'h00209233, 32'hC, 32'd7, 32'h25, mk(6'd9, 32'd7, 32'd5, 5'd4, 1'b1, 1'b0, 32'd4));          // sll x4,x1,x2
    issue(32'h123453B7, 32'h10, 32'hDEAD, 32'd0, mk(6'd19, 32'd0, 32'h12345000, 5'd7, 1'b1, 1'b0, 32'd5)); // lui x7
    issue(32'h12345037, 32'h14, 32'd0, 32'd0, mk(6'd19, 32'd0, 32'h12345000, 5'd0, 1'b0, 1'b0, 32'd6));    // lui x0
    issue(32'h00001417, 32'h100, 32'd0, 32'd0, mk(6'd20, 32'h100, 32'h1000, 5'd8, 1'b1, 1'b0, 32'd7));     // auipc x8,1
    issue(32'hFFF08493, 32'h18, 32'd5, 32'd0, mk(6'd1, 32'd5, 32'hFFFFFFFF, 5'd9, 1'b1, 1'b0, 32'd8));     // addi x9,x1,-1
    issue(32'hFFF03513, 32'h1C, 32'd0, 32'd0, mk(6'd18, 32'd0, 32'hFFFFFFFF, 5'd10, 1'b1, 1'b0, 32'd9));   // sltiu x10,x0,-1
    issue(32'h4020C1B3, 32'h20, 32'd1, 32'd2, mk(6'd63, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1, 32'd9));           // xor with funct7 0x20
    issue(32'h40409293, 32'h24, 32'd1, 32'd0, mk(6'd63, 32'd0, 32'd0, 5'd5, 1'b0, 1'b1, 32'd9));           // slli with funct7 0x20
    @(posedge clk); #1;

    // Backpressure: bundle must hold while execute stalls, then flush kills it.
    bus.ex_ready = 1'b0;
    held = mk(6'd1, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 32'd10);
    issue(32'h00500093, 32'h28, 32'd0, 32'd0, held);
    bus.if_instr = 32'h002081B3;
    bus.rs1_data = 32'd77;
    bus.rs2_data = 32'd88;
    bus.if_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_id_ready", 32'(bus.id_ready), 32'd0);
      chk("bp_ex_valid", 32'(bus.ex_valid), 32'd1);
      chk("bp_ex_type", 32'(bus.ex_type), 32'(held.ty));
      chk("bp_operand1", bus.operand1, held.op1);
      chk("bp_operand2", bus.operand2, held.op2);
      chk("bp_count", bus.decoded_count, held.cnt);
      @(posedge clk); #1;
    end
    void'(sb.pop_back());
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.if_valid = 1'b0;
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_count", bus.decoded_count, 32'd10);
    bus.ex_ready = 1'b1;

    issue(32'h00000000, 32'h2C, 32'd3, 32'd4, mk(6'd63, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'd10));       // bad opcode
    @(posedge clk); #1;

    // Asynchronous reset while a bundle is held.
    bus.ex_ready = 1'b0;
    issue(32'h00500093, 32'h30, 32'd0, 32'd0, mk(6'd1, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 32'd11));
    void'(sb.pop_back());
    chk("pre_reset_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("pre_reset_count", bus.decoded_count, 32'd11);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    #1 rst_n = 1'b1;
    bus.ex_ready = 1'b1;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- RV32I integer decode stage with its output pipeline register.
- Produces the {operand1, operand2, ex_type} bundle consumed by the execute-stage ALU, plus the writeback control for that instruction.
- Sits between the fetch stage (valid/ready in) and execute (valid/ready out).
- Drives the register-file read addresses combinationally and registers the decoded result.

Parameters:
- CNT_W, 32, width of the decoded-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill the held instruction and the incoming one.
- if_valid  in  1  fetch offers an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- id_ready  out  1  decode accepts this cycle.
- rs1_addr  out  5  regfile read address = if_instr[19:15], combinational.
- rs2_addr  out  5  regfile read address = if_instr[24:20], combinational.
- rs1_data  in  32  regfile data for rs1_addr, same cycle.
- rs2_data  in  32  regfile data for rs2_addr, same cycle.
- ex_valid  out  1  registered bundle valid.
- ex_ready  in  1  execute accepts bundle.
- operand1  out  32  ALU operand 1.
- operand2  out  32  ALU operand 2.
- ex_type  out  6  ALU operation code.
- rd_addr  out  5  destination register.
- reg_write  out  1  writeback enable.
- illegal  out  1  unsupported or malformed encoding.
- decoded_count  out  CNT_W  count of legal instructions handed to execute.

Behaviour:
- **Reset:** all registered outputs are 0: ex_valid, operand1, operand2, ex_type, rd_addr, reg_write, illegal, decoded_count.
- **Ready:** id_ready = !ex_valid | ex_ready. Accept = if_valid & id_ready & !flush.
- **Register update:**
  - On accept, load the decoded bundle and set ex_valid=1.
  - Else if ex_ready & ex_valid, clear ex_valid.
  - Otherwise the bundle holds bit-stable.
- **Latency:** one cycle from accept to ex_valid.
- **Flush:** has priority; next cycle ex_valid=0 regardless of if_valid/ex_ready. Data fields may keep stale values.
- **ex_type coding** (fixed):
  - 0 add, 1 addi, 2 sub, 3 and, 4 andi, 5 or, 6 ori, 7 xor, 8 xori
  - 9 sll, 10 slli, 11 srl, 12 srli, 13 sra, 14 srai
  - 15 slt, 16 slti, 17 sltu, 18 sltiu
  - 19 lui (pass operand2), 20 auipc (add)
- **OP (0110011):**
  - operand1=rs1_data.
  - operand2=rs2_data, except for sll/srl/sra, where operand2={27'b0, rs2_data[4:0]}.
  - funct7 must be 0000000, or 0100000 only for funct3 000 (sub) or 101 (sra); otherwise illegal.
- **OP-IMM (0010011):**
  - operand1=rs1_data.
  - operand2 = sign-extended instr[31:20], including for sltiu.
  - For slli/srli/srai: operand2={27'b0, instr[24:20]}. instr[31:25] must be 0000000, or 0100000 only for srai; otherwise illegal.
- **LUI (0110111):** operand1=0, operand2={instr[31:12], 12'b0}, ex_type 19.
- **AUIPC (0010111):** operand1=if_pc, operand2={instr[31:12], 12'b0}, ex_type 20.
- **Any other opcode:** illegal=1, ex_type=63, reg_write=0, operands 0, ex_valid still asserted so execute can trap.
- **rd_addr / reg_write:** rd_addr=instr[11:7]. reg_write=1 for legal decodes with rd!=0; reg_write=0 when rd=0.
- **decoded_count:** increments by 1 on each accept of a legal instruction; wraps modulo 2^CNT_W; unaffected by flush.
- **Reset mid-operation:** everything returns to the reset values immediately, without waiting for a clock edge.

Test Plan:
- **addi x1,x0,5:** reset, then if_instr=0x00500093, rs1_data=0, if_valid=1, ex_ready=1 -> next cycle ex_valid=1, ex_type=1, operand1=0, operand2=5, rd_addr=1, reg_write=1, decoded_count=1.
- **sub x3,x1,x2:** if_instr=0x402081B3, rs1_data=10, rs2_data=3 -> rs1_addr=1, rs2_addr=2 same cycle; next cycle ex_type=2, operand1=10, operand2=3.
- **srai x5,x6,4:** if_instr=0x40435293 -> ex_type=14, operand2=4.
  - Also sll with rs2_data=0x25 -> operand2=5.
- **lui x7,0x12345:** if_instr=0x123453B7 -> ex_type=19, operand1=0, operand2=0x12345000, rd_addr=7.
  - Same with rd=0 -> reg_write=0.
- **Backpressure:** ex_valid=1, ex_ready=0, new if_valid -> id_ready=0 and the bundle stays unchanged for 3 cycles.
  - Then raise flush for one cycle -> ex_valid=0 next cycle and decoded_count unchanged.
- **Illegal and reset:** if_instr=0x00000000 -> ex_valid=1, illegal=1, ex_type=63, reg_write=0, count unchanged.
  - Assert rst_n=0 mid-cycle -> all outputs 0 before the next clk edge.
